// File: rtl/sun_uart_pkg.sv
// Shared UART definitions: frame FSM states, data-bit count, TX FIFO depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Also used by the receiver.

package sun_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;

  // Counter width that can hold the value n-1. It is never less than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO. The depth must be a power of two.
// Latency: a push is visible at pop_dat on the cycle after it is written.
// Backpressure: push is ignored when full, pop is ignored when empty.
// A push and a pop in the same cycle are both honoured.
// Ports: clk, rst (async active-high), push_vld/push_dat, pop_rdy/pop_dat,
//        full, empty.

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The pointers carry one extra wrap bit, so full and empty can be told apart.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign pop_dat = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_dat;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter. It sends one byte per frame, LSB first.
// Latency: the start bit begins the cycle after the load. A frame lasts
//          10*CLKS_PER_BIT cycles.
// Backpressure: data_in_ready is high only in IDLE. With the FIFO option it
//               means the FIFO is not full. A pending valid waits with no
//               side effects.
// Option macro: UART_TX_FIFO_EN adds a 4-entry byte FIFO in front of the FSM.
// Ports: clk, rst (async active-high), data_in/data_in_valid/data_in_ready
//        (byte handshake), serial_out (TX line, idle high), busy (frame in
//        progress or byte pending).

module uart_transmitter
  import sun_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic                 serial_out,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W        = cnt_width(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic                 load;
  logic [DATA_BITS-1:0] load_dat;

`ifdef UART_TX_FIFO_EN
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_pop_dat;

  // Pop whenever the FSM is idle. The popped byte is loaded on the same
  // edge, so the start bit begins on the next cycle.
  assign load          = (state_q == IDLE) && !fifo_empty;
  assign load_dat      = fifo_pop_dat;
  assign data_in_ready = !fifo_full;
  assign busy          = (state_q != IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (data_in_valid),
    .push_dat (data_in),
    .pop_rdy  (load),
    .pop_dat  (fifo_pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
`else
  assign data_in_ready = (state_q == IDLE);
  assign load          = data_in_valid && data_in_ready;
  assign load_dat      = data_in;
  assign busy          = (state_q != IDLE);
`endif

  assign serial_out = tx_q;

  // tx_d holds the line level for the next cycle, so serial_out is a flop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          state_d    = START;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = load_dat;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (baud_cnt_q == BAUD_LAST) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_cnt_q == BAUD_LAST) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter, with CLKS_PER_BIT = 10.
// A scoreboard queue holds each accepted byte. A line monitor decodes every
// frame and checks it against the head of the queue.

module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       busy;

  uart_transmitter #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_FIFO_EN
  localparam int LAT      = 2;
  localparam int BUSY_EXP = 101;
`else
  localparam int LAT      = 1;
  localparam int BUSY_EXP = 100;
`endif

  typedef struct {
    logic [7:0] d;
    int         acc;
    bit         chk_lat;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle counters over windows whose end points are known to be zero.
  bit busy_cnt_en = 0;
  int busy_cnt    = 0;
  bit rdy_cnt_en  = 0;
  int rdy_cnt     = 0;

  always @(negedge clk) begin
    if (busy_cnt_en && busy) busy_cnt++;
    if (rdy_cnt_en && data_in_ready) rdy_cnt++;
  end

  // Line monitor.
  bit         mon_active = 0;
  logic [9:0] mon_v;
  bit         mon_ok;
  bit         mon_abort;
  int         mon_st;
  int         last_stop = -1;
  int         last_gap  = -1;
  exp_t       mon_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && serial_out === 1'b0) begin
        mon_active = 1;
        mon_st     = cyc;
        mon_v      = '0;
        mon_ok     = 1;
        mon_abort  = 0;
        if (last_stop >= 0) last_gap = mon_st - last_stop - 1;
        for (int i = 0; i < 100; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            mon_abort = 1;
            break;
          end
          if (i % 10 == 0) mon_v[i/10] = serial_out;
          else if (serial_out !== mon_v[i/10]) mon_ok = 0;
        end
        chk("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          if (!mon_abort) begin
            chk("frame_bits", mon_v, {1'b1, mon_e.d, 1'b0});
            chk("bit_stable", mon_ok, 1);
            if (mon_e.chk_lat) chk("start_latency", mon_st - mon_e.acc, LAT);
            last_stop = cyc;
          end
        end
        mon_active = 0;
      end
    end
  end

  // The caller must be at a negedge. The task returns at the negedge after
  // the accepting edge.
  task automatic send(input logic [7:0] b, input bit keep, input bit chk_lat);
    int   n;
    exp_t e;
    data_in_valid = 1'b1;
    data_in       = b;
    n = 0;
    while (!data_in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      chk("send_timeout", n, 0);
    end else begin
      e.d = b; e.acc = cyc; e.chk_lat = chk_lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!keep) begin
      data_in_valid = 1'b0;
      data_in       = 8'hFF;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 3000, 1);
    @(negedge clk);
  endtask

  logic [7:0] fifo_bytes [5];

  initial begin
    rst           = 1'b1;
    data_in_valid = 1'b0;
    data_in       = 8'h00;
    fifo_bytes[0] = 8'h11; fifo_bytes[1] = 8'h22; fifo_bytes[2] = 8'h33;
    fifo_bytes[3] = 8'h44; fifo_bytes[4] = 8'h55;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_serial_out", serial_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0xA5, with the busy duration measured.
    busy_cnt    = 0;
    busy_cnt_en = 1;
    send(8'hA5, 0, 1);
    wait_done();
    busy_cnt_en = 0;
    chk("busy_cycles", busy_cnt, BUSY_EXP);

`ifdef UART_TX_FIFO_EN
    // FIFO fill: five pushes on consecutive cycles.
    for (int i = 0; i < 5; i++) send(fifo_bytes[i], (i < 4), 0);
    chk("fifo_full_ready", data_in_ready, 0);
    chk("fifo_busy", busy, 1);
    wait_done();
    chk("fifo_ready_back", data_in_ready, 1);
`else
    // Back-to-back frames with valid held high.
    send(8'h00, 1, 1);
    rdy_cnt    = 0;
    rdy_cnt_en = 1;
    send(8'hFF, 0, 1);
    rdy_cnt_en = 0;
    wait_done();
    chk("b2b_idle_gap", last_gap, 1);
    chk("b2b_ready_pulses", rdy_cnt, 1);
`endif

    // Reset in the middle of frame 0x3C.
    send(8'h3C, 0, 1);
    repeat (34) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_serial_out", serial_out, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", data_in_ready, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_discarded", exp_q.size(), 0);
    send(8'hC3, 0, 1);
    wait_done();

    // data_in changes the cycle after the load.
    send(8'h5A, 0, 1);
    wait_done();

    chk("sb_drained", exp_q.size(), 0);
    chk("idle_line", serial_out, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, the serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port data_in  input  8  byte to transmit (the MMIO transmit-data byte).
REQ-006 SHALL have port data_in_valid  input  1  data_in holds a byte offered for transmission.
REQ-007 SHALL have port data_in_ready  output  1  block accepts data_in this cycle.
REQ-008 SHALL have port serial_out  output  1  UART TX line; idle high.
REQ-009 SHALL have port busy  output  1  frame in progress or byte pending; feeds the MMIO UART control register.

Function
REQ-010 SHALL compute CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE, truncating the remainder, with a counter just wide enough for CLKS_PER_BIT-1.
REQ-011 SHALL transfer a byte only on a posedge where data_in_valid and data_in_ready are both high; data_in is ignored at all other times.
REQ-012 SHALL implement FSM states IDLE, START, DATA and STOP; transitions:
- IDLE->START on a load; START->DATA after CLKS_PER_BIT cycles
- DATA->STOP after 8 bits; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-013 SHALL drive serial_out low from the cycle after the load and hold it for exactly CLKS_PER_BIT cycles (start bit).
REQ-014 SHALL send 8 data bits LSB first, each for exactly CLKS_PER_BIT cycles, then a stop bit held high for exactly CLKS_PER_BIT cycles: 8N1, 10*CLKS_PER_BIT cycles per frame.
REQ-015 SHALL latch data_in into an internal shift register at the load; later changes to data_in do not affect the frame in flight.
REQ-016 SHALL hold serial_out high in IDLE.
REQ-017 SHALL assert busy whenever the FSM is not in IDLE, or (with the FIFO) the FIFO is non-empty.
REQ-018 SHALL, without the FIFO, assert data_in_ready only in IDLE, and start the next frame on the cycle after the STOP->IDLE transition when valid is already high (back-to-back frames: one idle-high cycle between stop and start).
REQ-019 SHALL leave an asserted data_in_valid pending, with no side effects, while data_in_ready is low.

Reset
REQ-020 SHALL, while rst is high, force the FSM to IDLE, clear the bit and baud counters, drive serial_out=1, busy=0 and data_in_ready=1, and empty the FIFO if present.
REQ-021 SHALL abort a frame in flight when rst is asserted mid-frame, with serial_out high immediately (asynchronous); the aborted byte is discarded.
REQ-022 SHALL begin normal operation on the first posedge after rst deasserts.

Configuration
REQ-023 SHALL, when macro UART_TX_FIFO_EN is defined, place a 4-entry byte FIFO between the input handshake and the FSM:
- data_in_ready = FIFO not full
- FSM pops one entry when in IDLE and the FIFO is non-empty, starting the frame on the next cycle
- a push and pop in the same cycle are both honoured; ordering is FIFO.
REQ-024 SHALL, when UART_TX_FIFO_EN is undefined, have no FIFO; handshake per REQ-018.

Structure
REQ-025 SHALL place the FSM state enum (IDLE/START/DATA/STOP), the data-bit count 8 and the FIFO depth 4 in shared package sun_uart_pkg, reused by the future receiver.
REQ-026 SHALL implement the FIFO as sub-module uart_tx_fifo, instantiated only under UART_TX_FIFO_EN.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, CLKS_PER_BIT=10)
REQ-027 SHALL cover a single byte: load 0xA5 -> serial_out low for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles; busy high for exactly 100 cycles.
REQ-028 SHALL cover back-to-back: valid held high with 0x00 then 0xFF, no FIFO -> two frames separated by one idle-high cycle; data_in_ready pulses once per frame, in IDLE.
REQ-029 SHALL cover FIFO fill (UART_TX_FIFO_EN): push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> ready drops when full, 0x55 is accepted after the first pop, and the output order is 0x11..0x55.
REQ-030 SHALL cover reset mid-frame: assert rst at cycle 35 of frame 0x3C -> serial_out=1 and busy=0 in the same cycle; after release, load 0xC3 -> correct frame 0xC3.
REQ-031 SHALL cover input change: change data_in from 0x5A to 0xFF one cycle after the load -> the transmitted bits equal 0x5A.
